// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pkg
// Description : Shared types and constants for the instruction fetch responder
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    localparam int c_DATA_W = 32;

    typedef enum logic [1:0] {
        ERR_OK       = 2'b00,
        ERR_MISALIGN = 2'b01,
        ERR_RANGE    = 2'b10
    } rsp_err_e;

    localparam logic [c_DATA_W-1:0] NOP_WORD = 32'h0000_0013;

    typedef struct packed {
        logic [c_DATA_W-1:0] instr;
        logic [c_DATA_W-1:0] addr;
        rsp_err_e            err;
    } rsp_rec_t;

endpackage
`default_nettype wire

// File: rtl/imem_fetch_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : imem_fetch_responder_if
// Description : Fetch request/response channels, flush and program-load port
// Revision    : 1.0 - initial release
// ============================================================================
interface imem_fetch_responder_if #(
    parameter int DATA_SIZE = 32,
    parameter int ADDR_W    = 8
);
    logic                 req_valid;
    logic                 req_ready;
    logic [DATA_SIZE-1:0] req_addr;
    logic                 flush;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [DATA_SIZE-1:0] rsp_instr;
    logic [DATA_SIZE-1:0] rsp_addr;
    logic [1:0]           rsp_err;
    logic                 wr_en;
    logic [ADDR_W-1:0]    wr_addr;
    logic [DATA_SIZE-1:0] wr_data;

    modport master (
        output req_valid, req_addr, flush, rsp_ready, wr_en, wr_addr, wr_data,
        input  req_ready, rsp_valid, rsp_instr, rsp_addr, rsp_err
    );

    modport slave (
        input  req_valid, req_addr, flush, rsp_ready, wr_en, wr_addr, wr_data,
        output req_ready, rsp_valid, rsp_instr, rsp_addr, rsp_err
    );
endinterface
`default_nettype wire

// File: rtl/imem_rsp_fifo.sv
`default_nettype none
// ============================================================================
// Module      : imem_rsp_fifo
// Description : Synchronous FIFO of response records with push/pop/clear
// Revision    : 1.0 - initial release
// ============================================================================
module imem_rsp_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 3
) (
    input  wire logic     clk,
    input  wire logic     rst,
    input  wire logic     i_clear,
    input  wire logic     i_push,
    input  rsp_rec_t      i_rec,
    input  wire logic     i_pop,
    output rsp_rec_t      o_head,
    output logic          o_full,
    output logic          o_empty
);
    localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_CNT_W = $clog2(DEPTH + 1);

    rsp_rec_t            r_mem [DEPTH];
    logic [c_PTR_W-1:0]  r_wr_ptr;
    logic [c_PTR_W-1:0]  r_rd_ptr;
    logic [c_CNT_W-1:0]  r_count;
    logic                w_do_push;
    logic                w_do_pop;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == c_CNT_W'(DEPTH));
    assign o_head    = r_mem[r_rd_ptr];
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    function automatic logic [c_PTR_W-1:0] next_ptr(input logic [c_PTR_W-1:0] ptr);
        return (ptr == c_PTR_W'(DEPTH - 1)) ? '0 : ptr + c_PTR_W'(1);
    endfunction

    // A clear that coincides with a push keeps only the new record, in slot 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_clear) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= i_push ? c_PTR_W'(1) : '0;
            r_count  <= i_push ? c_CNT_W'(1) : '0;
        end else begin
            if (w_do_push) r_wr_ptr <= next_ptr(r_wr_ptr);
            if (w_do_pop)  r_rd_ptr <= next_ptr(r_rd_ptr);
            r_count <= r_count + c_CNT_W'(w_do_push) - c_CNT_W'(w_do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (i_clear && i_push) r_mem[0]        <= i_rec;
            else if (w_do_push)    r_mem[r_wr_ptr] <= i_rec;
        end
    end
endmodule
`default_nettype wire

// File: rtl/imem_fetch_responder.sv
`default_nettype none
// ============================================================================
// Module      : imem_fetch_responder
// Description : Fixed-latency instruction memory responder with flush support
// Revision    : 1.0 - initial release
// ============================================================================
module imem_fetch_responder #(
    parameter int                    DATA_SIZE = 32,
    parameter int                    ADDR_W    = 8,
    parameter int                    LATENCY   = 2,
    parameter logic [DATA_SIZE-1:0]  NOP_WORD  = fetch_pkg::NOP_WORD
) (
    input  wire logic               clk,
    input  wire logic               areset,
    imem_fetch_responder_if.slave   bus
);
    import fetch_pkg::*;

    localparam int c_FIFO_DEPTH = LATENCY + 1;
    localparam int c_CNT_W      = $clog2(LATENCY + 2);

    logic [DATA_SIZE-1:0] r_mem [2**ADDR_W];
    logic [c_CNT_W-1:0]   r_outstanding;
    rsp_rec_t             w_rec;
    rsp_rec_t             w_push_rec;
    rsp_rec_t             w_head;
    logic                 w_push;
    logic                 w_accept;
    logic                 w_pop;
    logic                 w_full;
    logic                 w_empty;

    assign bus.req_ready = (r_outstanding < c_CNT_W'(LATENCY + 1));
    assign w_accept      = bus.req_valid && bus.req_ready;
    assign w_pop         = !w_empty && bus.rsp_ready;

    // Errored fetches never index the array; they carry the NOP instead.
    always_comb begin
        w_rec.addr  = bus.req_addr;
        w_rec.err   = ERR_OK;
        w_rec.instr = NOP_WORD;
        if (bus.req_addr[1:0] != 2'b00) begin
            w_rec.err = ERR_MISALIGN;
        end else if (bus.req_addr[DATA_SIZE-1:ADDR_W+2] != '0) begin
            w_rec.err = ERR_RANGE;
        end else begin
            w_rec.instr = r_mem[bus.req_addr[ADDR_W+1:2]];
        end
    end

    always_ff @(posedge clk) begin
        if (bus.wr_en && !areset) r_mem[bus.wr_addr] <= bus.wr_data;
    end

    generate
        if (LATENCY == 1) begin : g_direct
            assign w_push     = w_accept;
            assign w_push_rec = w_rec;
        end else begin : g_pipe
            logic [LATENCY-2:0] r_vld;
            rsp_rec_t           r_rec [LATENCY-1];

            // Stage 0 always takes the current accept, so a fetch accepted
            // alongside a flush survives while every older stage is killed.
            always_ff @(posedge clk) begin
                if (areset) begin
                    r_vld <= '0;
                end else begin
                    r_vld[0] <= w_accept;
                    for (int i = 1; i < LATENCY - 1; i++) begin
                        r_vld[i] <= r_vld[i-1] && !bus.flush;
                    end
                end
                r_rec[0] <= w_rec;
                for (int i = 1; i < LATENCY - 1; i++) begin
                    r_rec[i] <= r_rec[i-1];
                end
            end

            assign w_push     = r_vld[LATENCY-2] && !bus.flush;
            assign w_push_rec = r_rec[LATENCY-2];
        end
    endgenerate

    imem_rsp_fifo #(
        .DEPTH   (c_FIFO_DEPTH)
    ) u_rsp_fifo (
        .clk     (clk),
        .rst     (areset),
        .i_clear (bus.flush),
        .i_push  (w_push),
        .i_rec   (w_push_rec),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge clk) begin
        if (areset) begin
            r_outstanding <= '0;
        end else if (bus.flush) begin
            r_outstanding <= c_CNT_W'(w_accept);
        end else begin
            r_outstanding <= r_outstanding + c_CNT_W'(w_accept) - c_CNT_W'(w_pop);
        end
    end

    // The counter caps occupancy at the FIFO depth, so full is never reached
    // with a pending push.
    logic w_unused;
    assign w_unused = w_full;

    assign bus.rsp_valid = !w_empty;
    assign bus.rsp_instr = w_empty ? '0 : w_head.instr;
    assign bus.rsp_addr  = w_empty ? '0 : w_head.addr;
    assign bus.rsp_err   = w_empty ? 2'b00 : w_head.err;
endmodule
`default_nettype wire

// File: doc/imem_fetch_responder.md
Name: imem_fetch_responder

Overview:
- Instruction-memory responder on the far end of the PC fetch interface.
- Accepts fetch addresses from the PC/fetch stage over a valid/ready request channel.
- Reads a word-addressed instruction ROM/RAM through a fixed-latency pipeline and returns instruction words in order over a valid/ready response channel.
- Supports branch redirect (flush), error tagging, and a back-door write port for program load.

Parameters:
- data_Size, 32, instruction/address width in bits.
- ADDR_W, 8, memory index width; depth = 2^ADDR_W words.
- LATENCY, 2, request-accept to response-valid cycles; legal range 1..4.
- NOP_WORD, 32'h00000013, instruction returned on any error response.

Ports:
- clk  in  1  clock; all logic on rising edge.
- areset  in  1  synchronous, active-high reset.
- req_valid  in  1  fetch request valid.
- req_ready  out  1  responder can accept a request.
- req_addr  in  data_Size  byte address (PC value).
- flush  in  1  redirect: discard all older outstanding fetches.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  consumer accepts response.
- rsp_instr  out  data_Size  instruction word.
- rsp_addr  out  data_Size  echoed request address.
- rsp_err  out  2  00 ok, 01 misaligned, 10 out of range.
- wr_en  in  1  program-load write strobe.
- wr_addr  in  ADDR_W  word index for write.
- wr_data  in  data_Size  write data.

Behaviour:
- Reset, sampled at the clk edge with areset=1: pipeline and output FIFO emptied; outstanding count 0; rsp_valid=0, rsp_instr=0, rsp_addr=0, rsp_err=0; req_ready=1 in the cycle after reset. Memory contents are not cleared.
- Reset mid-operation discards all in-flight fetches; no response for them is ever produced.
- Accept: handshake completes on req_valid && req_ready at a clk edge. The memory read for word req_addr[ADDR_W+1:2] happens in the accept cycle.
- Latency: rsp_valid for an accepted request is first asserted LATENCY cycles after its accept edge, provided rsp_ready has been held 1.
- Ordering: responses always leave in accept order.
- Output FIFO depth is LATENCY+1; an outstanding counter tracks pipeline plus FIFO occupancy.
- req_ready = (outstanding < LATENCY+1). It is driven from registers only, with no combinational path from rsp_ready.
- With rsp_ready held 1, back-to-back requests sustain one response per cycle.
- Back-pressure: when rsp_ready=0, rsp_valid, rsp_instr, rsp_addr and rsp_err are held stable until the handshake completes.
- Counter update per edge: +1 on accept, -1 on response handshake; both in the same cycle leave it unchanged.
- Error classification, in priority order:
  - req_addr[1:0] != 0: rsp_err=01.
  - else req_addr[data_Size-1:ADDR_W+2] != 0: rsp_err=10.
  - Any error: rsp_instr=NOP_WORD and no memory read is performed.
- flush=1 at an edge invalidates every fetch accepted before that edge, in both pipeline and FIFO. The counter is reset to the number of survivors.
- A request accepted in the same cycle as flush survives and is the first response after the redirect.
- A response handshake in the flush cycle does complete. That word was already consumed and is not re-issued.
- Write port: wr_en writes mem[wr_addr] at the edge. A read of the same word in the same cycle returns the old data (read-before-write).
- wr_en is ignored while areset=1.

Decomposition:
- Shared package fetch_pkg holds:
  - rsp_err encodings (ERR_OK, ERR_MISALIGN, ERR_RANGE).
  - NOP_WORD.
  - The response record type {instr, addr, err}.
- Natural sub-module: imem_rsp_fifo. It is a synchronous FIFO of response records with depth LATENCY+1, with push/pop/clear, full and empty.
- The top level holds the memory array, the LATENCY-stage valid/data shift pipeline, error classification and the outstanding counter.

Test Plan:
- Load mem[0..3]=A0,A1,A2,A3; request 0x0,0x4,0x8,0xC back-to-back with rsp_ready=1 and LATENCY=2 -> rsp_valid on cycles 2,3,4,5 with instr A0..A3, err=00, and req_ready always 1.
- rsp_ready=0, issue requests until req_ready drops -> exactly 3 accepted (LATENCY+1); rsp_instr held stable; after releasing rsp_ready, all 3 drain in order.
- Request 0x6, then 0x400 (ADDR_W=8) -> responses carry NOP 32'h00000013 with rsp_err=01, then NOP with rsp_err=10.
- Two fetches in flight, then flush together with a new request to 0x10 -> only mem[4] is returned; the old fetches never appear and the counter reads 1.
- Assert areset mid-stream with 2 outstanding -> rsp_valid=0 next cycle, req_ready=1, no stale responses afterwards; memory contents retained.
- In the same cycle, wr_en to word 5 with 0xDEADBEEF and a fetch of 0x14 -> returns the old word; a repeat fetch returns 0xDEADBEEF.
